fir_mac_sequencer: RTL and testbench
====================================

# fir_mac_sequencer

Control and data sequencer that drives the `MAC` datapath and turns it into a TAPS-tap FIR filter for the audio DSP chain. It accepts one audio sample per valid/ready handshake and stores it in a circular delay line. It then clears the MAC and streams sample/coefficient pairs into it, one per cycle. It captures the 32-bit accumulator result and presents it on a valid/ready output port.

## Interface
- `TAPS`, 8: number of filter taps; power of two, 2–64.
- `DATA_W`, 16: sample and coefficient width, signed two's complement.
- `ACC_W`, 32: accumulator/result width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input sample offered.
- `in_ready` out 1: sequencer can accept a sample.
- `in_sample` in DATA_W: new audio sample x[n].
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in log2(TAPS): coefficient index k.
- `coef_data` in DATA_W: coefficient value h[k].
- `mac_A` out DATA_W: sample operand to MAC.
- `mac_B` out DATA_W: coefficient operand to MAC.
- `mac_en` out 1: MAC accumulate enable.
- `mac_rst` out 1: MAC accumulator clear.
- `mac_out` in ACC_W: MAC accumulator value.
- `out_valid` out 1: filtered result available.
- `out_ready` in 1: downstream accepts result.
- `out_sample` out ACC_W: y[n] = Σ h[k]·x[n−k], k = 0..TAPS−1.

## Operation
- MAC contract: on each rising edge, `mac_rst`=1 sets the accumulator to 0 and has priority. Otherwise `mac_en`=1 adds signed `mac_A`·`mac_B`. The result is visible on `mac_out` in the following cycle. Wrap-around is modulo 2^ACC_W, and no saturation is applied.
- Storage:
  - Delay line: TAPS×DATA_W ring with write pointer `wr_ptr`.
  - Coefficient register file: TAPS×DATA_W.
- FSM states: IDLE, CLEAR, ACCUM, DRAIN, OUT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, write `in_sample` at `wr_ptr` and go to CLEAR.
- CLEAR:
  - `mac_rst`=1 for one cycle.
  - Tap counter k←0, then go to ACCUM.
- ACCUM:
  - `mac_en`=1.
  - `mac_A`=ring[(wr_ptr−k) mod TAPS] and `mac_B`=coef[k].
  - k increments every cycle. After k=TAPS−1, go to DRAIN.
- DRAIN:
  - `mac_en`=0.
  - `out_sample`←`mac_out`; advance `wr_ptr` by 1, wrapping at TAPS.
  - Go to OUT.
- OUT:
  - `out_valid`=1, with `out_sample` held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.
- `mac_A`, `mac_B` and `mac_en` are 0 outside ACCUM.
- `mac_rst` = `rst` OR (state==CLEAR), so the MAC is also cleared throughout reset.
- Coefficient writes are honoured only in IDLE. `coef_we` in any other state is ignored with no effect.
- `in_valid` outside IDLE is not accepted. The sample must be held by the producer until `in_ready`.

## Timing
- Reset values:
  - State IDLE, `wr_ptr`=0, k=0.
  - Ring and coefficients all 0.
  - `in_ready`=1 after release (0 while `rst` high).
  - `out_valid`=0, `out_sample`=0, `mac_A`=`mac_B`=0, `mac_en`=0.
  - `mac_rst`=1 while `rst` high.
- Latency, with the input handshake in cycle 0:
  - CLEAR in cycle 1.
  - ACCUM in cycles 2..TAPS+1.
  - DRAIN in cycle TAPS+2.
  - `out_valid` first high in cycle TAPS+3 (cycle 11 for TAPS=8).
- Throughput: at most one sample per TAPS+4 cycles with `out_ready` tied high.
- A coefficient write in the same IDLE cycle as an input handshake takes effect for that sample.
- Output backpressure: OUT is held indefinitely, and `in_ready` stays 0 throughout.
- Reset asserted in any state: all state and storage return to reset values immediately. Any in-flight result is discarded and never presented.

## Structure
- Package `fir_pkg`:
  - State enum `fir_state_t` (IDLE, CLEAR, ACCUM, DRAIN, OUT).
  - Default width constants DATA_W=16 and ACC_W=32.
  - Function for the ring index (wr_ptr−k) mod TAPS.
- One sub-module, `sample_ring`:
  - Circular delay line with write port, `wr_ptr` and an indexed combinational read port.
  - Instantiated once.
- Coefficient file and FSM live in `fir_mac_sequencer`.
- The bench instantiates `MAC` beside the sequencer and connects the mac_* ports.

## Test plan
- Reset: `rst`=1 for 100 ns, then release.
  - During reset: `mac_rst`=1 and `in_ready`=0.
  - After release: `in_ready`=1.
  - Throughout: `out_valid`=0 and `out_sample`=0.
- Impulse:
  - Stimulus: h = 1,2,…,8; feed 1 followed by 7 zeros, with `out_ready`=1.
  - Outputs: 1,2,3,…,8. A ninth zero input gives 0.
  - Each `out_valid` appears exactly 11 cycles after its input handshake.
- DC:
  - Stimulus: h all 2; feed 20 eight times.
  - Outputs: 40, 80, …, 320.
- Signed:
  - Stimulus: h[0]=−3, rest 0; feed 20.
  - Output: `out_sample`=32'hFFFFFFC4 (−60).
- Backpressure and busy writes:
  - Stimulus: `out_ready`=0 for 10 cycles while `in_valid`=1 with 5; during ACCUM write coef[0]=100.
  - `out_valid` and `out_sample` stay stable, with `in_ready`=0.
  - The coefficient write is ignored: the readback impulse response is unchanged.
- Reset mid-ACCUM:
  - Stimulus: assert `rst` in cycle 4 after a handshake.
  - No `out_valid` for that sample.
  - After release, feeding 7 gives `out_sample`=0, because the coefficients are cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, default widths and ring indexing for the FIR sequencer
package fir_pkg;
  localparam int DATA_W = 16;
  localparam int ACC_W = 32;
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, OUT} fir_state_t;
  function automatic int unsigned ring_idx(input int unsigned wr_ptr, input int unsigned k, input int unsigned taps);
    return (wr_ptr - k) & (taps - 1);
  endfunction
endpackage

// File: rtl/MAC.sv
// MAC: signed multiply-accumulate, clear has priority, result wraps modulo 2^ACC_W
//   clr_i clears, en_i adds a_i*b_i, acc_o is the accumulator
module MAC #(
  parameter int DATA_W = 16,
  parameter int ACC_W = 32
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0] acc_q;
  assign prod = $signed(a_i) * $signed(b_i);
  always_ff @(posedge clk) begin
    if (clr_i) acc_q <= '0;
    else if (en_i) acc_q <= acc_q + ACC_W'(prod);
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/sample_ring.sv
// sample_ring: circular delay line with one write port, a write pointer and a combinational read port
//   we_i/data_i write at the pointer, adv_i steps the pointer, rd_idx_i/rd_data_o read any slot
module sample_ring #(
  parameter int TAPS = 8,
  parameter int DATA_W = 16,
  parameter int AW = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              adv_i,
  input  logic [AW-1:0]     rd_idx_i,
  output logic [AW-1:0]     wr_ptr_o,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] ring_q [TAPS];
  logic [AW-1:0] wr_ptr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q <= '{default: '0};
      wr_ptr_q <= '0;
    end else begin
      if (we_i) ring_q[wr_ptr_q] <= data_i;
      if (adv_i) wr_ptr_q <= wr_ptr_q + 1'b1;
    end
  end
  assign wr_ptr_o = wr_ptr_q;
  assign rd_data_o = ring_q[rd_idx_i];
endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: drives an external MAC to compute a TAPS-tap FIR output per accepted sample
//   in_*: sample handshake, coef_*: coefficient writes (IDLE only), mac_*: MAC datapath, out_*: result handshake
module fir_mac_sequencer #(
  parameter int TAPS = 8,
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int ACC_W = fir_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_sample,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [DATA_W-1:0]        coef_data,
  output logic [DATA_W-1:0]        mac_A,
  output logic [DATA_W-1:0]        mac_B,
  output logic                     mac_en,
  output logic                     mac_rst,
  input  logic [ACC_W-1:0]         mac_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sample
);
  import fir_pkg::*;
  localparam int AW = $clog2(TAPS);
  fir_state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d, wr_ptr, rd_idx;
  logic [DATA_W-1:0] coef_q [TAPS];
  logic [DATA_W-1:0] rd_data;
  logic [ACC_W-1:0] out_sample_q;
  logic hs, accum;
  assign hs = in_valid && in_ready;
  assign accum = state_q == ACCUM;
  assign rd_idx = AW'(ring_idx(32'(wr_ptr), 32'(k_q), TAPS));
  sample_ring #(.TAPS(TAPS), .DATA_W(DATA_W)) u_ring (
    .clk(clk), .rst(rst), .we_i(hs), .data_i(in_sample), .adv_i(state_q == DRAIN),
    .rd_idx_i(rd_idx), .wr_ptr_o(wr_ptr), .rd_data_o(rd_data)
  );
  always_comb begin
    state_d = state_q == IDLE  ? (hs ? CLEAR : IDLE) :
              state_q == CLEAR ? ACCUM :
              state_q == ACCUM ? (k_q == AW'(TAPS - 1) ? DRAIN : ACCUM) :
              state_q == DRAIN ? OUT :
              (out_ready ? IDLE : OUT);
    k_d = accum ? k_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      coef_q <= '{default: '0};
      out_sample_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      if (coef_we && state_q == IDLE) coef_q[coef_addr] <= coef_data;
      if (state_q == DRAIN) out_sample_q <= mac_out;
    end
  end
  // in_ready is gated by rst so nothing is accepted while reset is held
  assign in_ready = !rst && state_q == IDLE;
  assign mac_en = accum;
  assign mac_A = accum ? rd_data : '0;
  assign mac_B = accum ? coef_q[k_q] : '0;
  assign mac_rst = rst || state_q == CLEAR;
  assign out_valid = state_q == OUT;
  assign out_sample = out_sample_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed and randomized checks of the FIR sequencer against a convolution model
module tb_fir_mac_sequencer;
  localparam int TAPS = 8;
  logic clk = 0, rst = 1, in_valid = 0, coef_we = 0, out_ready = 1;
  logic [15:0] in_sample = '0, coef_data = '0;
  logic [2:0] coef_addr = '0;
  logic in_ready, mac_en, mac_rst, out_valid;
  logic [15:0] mac_A, mac_B;
  logic [31:0] mac_out, out_sample;
  int n_checks = 0, n_fail = 0;
  int h_m [TAPS];
  int x_m [TAPS];
  fir_mac_sequencer #(.TAPS(TAPS), .DATA_W(16), .ACC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .mac_A(mac_A), .mac_B(mac_B), .mac_en(mac_en), .mac_rst(mac_rst), .mac_out(mac_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample)
  );
  MAC #(.DATA_W(16), .ACC_W(32)) u_mac (
    .clk(clk), .clr_i(mac_rst), .en_i(mac_en), .a_i(mac_A), .b_i(mac_B), .acc_o(mac_out)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      h_m[i] = 0;
      x_m[i] = 0;
    end
  endtask
  task automatic model_push(input int x);
    for (int i = TAPS - 1; i > 0; i--) x_m[i] = x_m[i-1];
    x_m[0] = x;
  endtask
  function automatic logic [31:0] model_y();
    int acc = 0;
    for (int i = 0; i < TAPS; i++) acc += h_m[i] * x_m[i];
    return acc;
  endfunction
  task automatic wr_coef(input int a, input logic signed [15:0] d);
    coef_we = 1;
    coef_addr = 3'(a);
    coef_data = d;
    @(negedge clk);
    coef_we = 0;
    h_m[a] = int'(d);
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
  endtask
  task automatic do_sample(input logic signed [15:0] x, input int stall, output logic [31:0] y);
    logic [31:0] exp;
    int lat;
    model_push(int'(x));
    exp = model_y();
    in_valid = 1;
    in_sample = x;
    wait_ready();
    @(negedge clk);
    in_valid = 0;
    out_ready = stall == 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid", out_valid, 1);
    check("latency", lat, 11);
    check("y", out_sample, exp);
    y = out_sample;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_y", out_sample, exp);
    end
    out_ready = 1;
    @(negedge clk);
    check("out_done", out_valid, 0);
  endtask
  initial begin
    logic [31:0] y, held;
    int seen;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("rst_mac_rst", mac_rst, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sample", out_sample, 0);
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    check("rel_mac_rst", mac_rst, 0);
    check("rel_out_valid", out_valid, 0);
    check("rel_out_sample", out_sample, 0);
    check("rel_mac_en", mac_en, 0);
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'(i + 1));
    for (int i = 0; i < 9; i++) begin
      do_sample(i == 0 ? 16'sd1 : 16'sd0, 0, y);
      check("impulse", y, i < 8 ? 32'(i + 1) : 32'd0);
    end
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'sd2);
    for (int i = 0; i < 8; i++) begin
      do_sample(16'sd20, 0, y);
      check("dc", y, 32'(40 * (i + 1)));
    end
    wr_coef(0, -16'sd3);
    for (int i = 1; i < TAPS; i++) wr_coef(i, 16'sd0);
    do_sample(16'sd20, 0, y);
    check("signed", y, 32'hFFFFFFC4);
    for (int i = 0; i < TAPS; i++) wr_coef(i, 16'(i + 1));
    model_push(5);
    y = model_y();
    out_ready = 0;
    in_valid = 1;
    in_sample = 16'sd5;
    wait_ready();
    repeat (3) @(negedge clk);
    coef_we = 1;
    coef_addr = 3'd0;
    coef_data = 16'sd100;
    @(negedge clk);
    coef_we = 0;
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    check("bp_valid", out_valid, 1);
    check("bp_y", out_sample, y);
    held = out_sample;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_y", out_sample, held);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("bp_done", out_valid, 0);
    for (int i = 0; i < 8; i++) do_sample(i == 0 ? 16'sd1 : 16'sd0, 0, y);
    in_valid = 1;
    in_sample = 16'sd9;
    wait_ready();
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("mid_mac_rst", mac_rst, 1);
    check("mid_in_ready", in_ready, 0);
    check("mid_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_no_output", seen, 0);
    do_sample(16'sd7, 0, y);
    check("mid_cleared_coef", y, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) wr_coef($urandom_range(0, TAPS - 1), 16'($urandom));
      do_sample(16'($urandom), $urandom_range(0, 3), y);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
